// File: rtl/dispense_sequencer_if.sv
// Request/servo bus of the dispense sequencer; the sequencer takes the slave side.
interface dispense_sequencer_if;
    logic       req_valid;
    logic [3:0] req_med;
    logic [2:0] req_count;
    logic       req_ready;
    logic [3:0] med;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output req_valid, req_med, req_count,
        input  req_ready, med, busy, done, err
    );

    modport slave (
        input  req_valid, req_med, req_count,
        output req_ready, med, busy, done, err
    );
endinterface

// File: rtl/dispense_sequencer.sv
// Steps the servo code home->compartment->home per pill, then pulses done (err on reject/abort).
// Latency: med follows the handshake edge; k pills take k*(MOVE+HOLD+RET)+1 busy cycles.
// Backpressure: req_ready only in IDLE, no queueing. Macro PILL_SENSE_EN adds drop sensing.
module dispense_sequencer #(
    parameter logic [31:0] MOVE_CYC    = 32'd25_000_000,
    parameter logic [31:0] HOLD_CYC    = 32'd10_000_000,
    parameter logic [31:0] RET_CYC     = 32'd25_000_000
`ifdef PILL_SENSE_EN
   ,parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dispense_sequencer_if.slave        bus
`ifdef PILL_SENSE_EN
   ,input  logic                       pill_det
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MOVE   = 3'd1;
    localparam logic [2:0] ST_HOLD   = 3'd2;
    localparam logic [2:0] ST_RETURN = 3'd3;
    localparam logic [2:0] ST_SENSE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    logic [2:0]  state;
    logic [3:0]  med_q;
    logic [3:0]  target;
    logic [31:0] timer;
    logic [2:0]  remaining;

    logic code_ok;
    logic accept_ok;

    assign code_ok   = (bus.req_med == 4'h7) || (bus.req_med == 4'h8) ||
                       (bus.req_med == 4'h9) || (bus.req_med == 4'hC);
    assign accept_ok = code_ok && (bus.req_count != 3'd0);

    assign bus.med       = med_q;
    assign bus.req_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.err       = (state == ST_ERR);

`ifdef PILL_SENSE_EN
    logic [2:0] det_sync;
    logic       det_rise;
    logic       drop_seen;
    logic       enter_move;

    assign det_rise   = det_sync[1] & ~det_sync[2];
    assign enter_move = ((state == ST_IDLE) && bus.req_valid && accept_ok) ||
                        ((state == ST_SENSE) && drop_seen && (remaining != 3'd0));

    // det_sync[1:0] is the synchronizer; det_sync[2] is the previous sample for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_sync  <= 3'b000;
            drop_seen <= 1'b0;
        end else begin
            det_sync <= {det_sync[1:0], pill_det};
            if (enter_move)
                drop_seen <= 1'b0;
            else if (det_rise && ((state == ST_MOVE) || (state == ST_HOLD) ||
                                  (state == ST_RETURN) || (state == ST_SENSE)))
                drop_seen <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            med_q     <= 4'h0;
            target    <= 4'h0;
            timer     <= 32'd0;
            remaining <= 3'd0;
        end else begin
            if (timer != 32'd0)
                timer <= timer - 32'd1;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        target    <= bus.req_med;
                        remaining <= bus.req_count;
                        if (accept_ok) begin
                            state <= ST_MOVE;
                            med_q <= bus.req_med;
                            timer <= MOVE_CYC - 32'd1;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_MOVE: begin
                    if (timer == 32'd0) begin
                        state <= ST_HOLD;
                        timer <= HOLD_CYC - 32'd1;
                    end
                end
                ST_HOLD: begin
                    if (timer == 32'd0) begin
                        state <= ST_RETURN;
                        med_q <= 4'h0;
                        timer <= RET_CYC - 32'd1;
                    end
                end
                ST_RETURN: begin
                    if (timer == 32'd0) begin
                        remaining <= remaining - 3'd1;
`ifdef PILL_SENSE_EN
                        state <= ST_SENSE;
                        timer <= TIMEOUT_CYC - 32'd1;
`else
                        if (remaining == 3'd1) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_MOVE;
                            med_q <= target;
                            timer <= MOVE_CYC - 32'd1;
                        end
`endif
                    end
                end
`ifdef PILL_SENSE_EN
                ST_SENSE: begin
                    // a seen drop wins over a simultaneous timeout
                    if (drop_seen) begin
                        if (remaining == 3'd0) begin
                            state <= ST_DONE;
                            timer <= 32'd0;
                        end else begin
                            state <= ST_MOVE;
                            med_q <= target;
                            timer <= MOVE_CYC - 32'd1;
                        end
                    end else if (timer == 32'd0) begin
                        state     <= ST_ERR;
                        remaining <= 3'd0;
                    end
                end
`endif
                ST_DONE: begin
                    state     <= ST_IDLE;
                    remaining <= 3'd0;
                end
                ST_ERR: begin
                    state     <= ST_IDLE;
                    med_q     <= 4'h0;
                    remaining <= 3'd0;
                end
                default: begin
                    state <= ST_IDLE;
                    med_q <= 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: request table with scoreboard, plus reset-abort sequence.
module tb_dispense_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef PILL_SENSE_EN
    logic pill_det = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    dispense_sequencer_if bus ();

    dispense_sequencer #(
        .MOVE_CYC   (32'd4),
        .HOLD_CYC   (32'd3),
        .RET_CYC    (32'd5)
`ifdef PILL_SENSE_EN
       ,.TIMEOUT_CYC(32'd6)
`endif
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
`ifdef PILL_SENSE_EN
       ,.pill_det(pill_det)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] med;
        logic [2:0] cnt;
        bit         exp_done;   // 1: done pulse, 0: err pulse
        int         exp_busy;   // busy cycles; the pulse lands on the last one
        int         exp_tgt;    // cycles med shows the target (7 per started pill)
        int         pulse_at;   // cycle index of a pill_det pulse, -1 for none
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int guard, idx, busy_n, tgt_n, win_n, stray, done_n, err_n, both, pulse_idx, ready_bad;
        logic [3:0] prev;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", int'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_med   = v.med;
        bus.req_count = v.cnt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check("med_after_handshake", int'(bus.med), (v.exp_tgt > 0) ? int'(v.med) : 0);
        check("busy_after_handshake", int'(bus.busy), 1);
        check("ready_after_handshake", int'(bus.req_ready), 0);
        // keep presenting a different request while busy; it must be ignored
        bus.req_med   = (v.med == 4'h9) ? 4'h7 : 4'h9;
        bus.req_count = 3'd1;
        idx = 0; busy_n = 0; tgt_n = 0; win_n = 0; stray = 0;
        done_n = 0; err_n = 0; both = 0; pulse_idx = 0; ready_bad = 0;
        prev = 4'h0;
        do begin
            @(negedge clk);
            idx++;
`ifdef PILL_SENSE_EN
            pill_det = (idx == v.pulse_at);
`endif
            if (bus.busy) busy_n++;
            if (bus.req_ready == bus.busy) ready_bad++;
            if (v.med != 4'h0 && bus.med == v.med) begin
                tgt_n++;
                if (prev != v.med) win_n++;
            end else if (bus.med != 4'h0) begin
                stray++;
            end
            prev = bus.med;
            if (bus.done && bus.err) both++;
            if (bus.done) begin done_n++; pulse_idx = idx; bus.req_valid = 1'b0; end
            if (bus.err)  begin err_n++;  pulse_idx = idx; bus.req_valid = 1'b0; end
        end while (bus.busy && idx < 300);
        bus.req_valid = 1'b0;
        check("busy_bounded", int'(idx < 300), 1);
        e = sb.pop_front();
        check("busy_cycles", busy_n, e.exp_busy);
        check("target_cycles", tgt_n, e.exp_tgt);
        check("target_windows", win_n, e.exp_tgt / 7);
        check("stray_med_cycles", stray, 0);
        check("done_pulses", done_n, e.exp_done ? 1 : 0);
        check("err_pulses", err_n, e.exp_done ? 0 : 1);
        check("pulse_cycle", pulse_idx, e.exp_busy);
        check("done_err_together", both, 0);
        check("ready_vs_busy", ready_bad, 0);
        check("med_home_at_end", int'(bus.med), 0);
        check("ready_at_end", int'(bus.req_ready), 1);
    endtask

    task automatic reset_mid_hold();
        int idx, noise;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_med   = 4'h9;
        bus.req_count = 3'd2;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        // cycles 1-4 are MOVE, 5-7 are HOLD
        for (idx = 1; idx <= 6; idx++) @(negedge clk);
        check("rst_pre_med", int'(bus.med), 9);
        rst_n = 1'b0;
        #1;
        check("rst_async_med", int'(bus.med), 0);
        check("rst_async_busy", int'(bus.busy), 0);
        check("rst_async_ready", int'(bus.req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        noise = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done || bus.err || bus.busy || bus.med != 4'h0) noise++;
        end
        check("rst_no_activity", noise, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_med   = 4'h0;
        bus.req_count = 3'd0;

`ifdef PILL_SENSE_EN
        tbl.push_back('{4'h5, 3'd2, 1'b0, 1,  0,  -1});
        tbl.push_back('{4'h7, 3'd0, 1'b0, 1,  0,  -1});
        tbl.push_back('{4'h8, 3'd1, 1'b1, 14, 7,  5});
        tbl.push_back('{4'hC, 3'd2, 1'b0, 32, 14, 5});
        tbl.push_back('{4'h9, 3'd1, 1'b1, 14, 7,  2});
`else
        tbl.push_back('{4'h8, 3'd1, 1'b1, 13, 7,  -1});
        tbl.push_back('{4'hC, 3'd3, 1'b1, 37, 21, -1});
        tbl.push_back('{4'h5, 3'd2, 1'b0, 1,  0,  -1});
        tbl.push_back('{4'h7, 3'd0, 1'b0, 1,  0,  -1});
        tbl.push_back('{4'h7, 3'd2, 1'b1, 25, 14, -1});
        tbl.push_back('{4'h9, 3'd1, 1'b1, 13, 7,  -1});
        tbl.push_back('{4'h0, 3'd3, 1'b0, 1,  0,  -1});
        tbl.push_back('{4'hF, 3'd7, 1'b0, 1,  0,  -1});
        tbl.push_back('{4'hC, 3'd7, 1'b1, 85, 49, -1});
        tbl.push_back('{4'h9, 3'd0, 1'b0, 1,  0,  -1});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_med", int'(bus.med), 0);
        check("reset_ready", int'(bus.req_ready), 1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_err", int'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i]);

        reset_mid_hold();
        run_vec(tbl[0]);

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
